// File: rtl/battle_pkg.sv
// Shared types and constants for the battle damage engine.
// Move power tables and the FSM state encoding live here.
package battle_pkg;

    localparam int HP_W = 8;

    typedef enum logic {
        ATK_USER = 1'b0,
        ATK_BOSS = 1'b1
    } attacker_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ROLL,
        ST_APPLY,
        ST_RESP
    } dmg_state_t;

    localparam logic [7:0] USER_MOVE_POWER [4] = '{8'd8, 8'd12, 8'd16, 8'd24};
    localparam logic [7:0] BOSS_MOVE_POWER [4] = '{8'd10, 8'd14, 8'd18, 8'd30};

    function automatic logic [8:0] base_power(
        input attacker_t  atk,
        input logic [1:0] id
    );
        if (atk == ATK_USER) begin
            return {1'b0, USER_MOVE_POWER[id]};
        end
        return {1'b0, BOSS_MOVE_POWER[id]};
    endfunction

endpackage

// File: rtl/battle_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
// Also intended for boss move selection in the battle FSM.
module battle_lfsr (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed,
    output logic [7:0] out
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/battle_damage_engine.sv
// Executes user/boss moves: power lookup, crit roll, saturating HP subtract.
// One move per five cycles; init aborts any move and refills both HP bars.
module battle_damage_engine
    import battle_pkg::*;
#(
    parameter int unsigned USER_MAX_HP = 100,
    parameter int unsigned BOSS_MAX_HP = 120,
    parameter int unsigned CRIT_EN     = 1,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            init,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            attacker,
    input  logic [1:0]      move_id,
    output logic            resp_valid,
    output logic [7:0]      damage,
    output logic            crit,
    output logic [HP_W-1:0] user_hp,
    output logic [HP_W-1:0] boss_hp,
    output logic            user_fainted,
    output logic            boss_fainted
);

    localparam logic [HP_W-1:0] USER_HP_INIT = USER_MAX_HP[HP_W-1:0];
    localparam logic [HP_W-1:0] BOSS_HP_INIT = BOSS_MAX_HP[HP_W-1:0];

    dmg_state_t      state_q, state_d;
    attacker_t       atk_q, atk_d;
    logic [1:0]      mid_q, mid_d;
    logic [8:0]      base_q, base_d;
    logic [7:0]      dmg_q, dmg_d;
    logic            roll_crit_q, roll_crit_d;
    logic [HP_W-1:0] user_hp_q, user_hp_d;
    logic [HP_W-1:0] boss_hp_q, boss_hp_d;
    logic [7:0]      damage_q, damage_d;
    logic            crit_q, crit_d;

    logic [7:0]      lfsr_w;
    logic            roll_hit;
    logic [9:0]      scaled;

    battle_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .out   (lfsr_w)
    );

    assign roll_hit = (CRIT_EN != 0) && ((lfsr_w & 8'h07) == 8'h00);

    always_comb begin
        state_d     = state_q;
        atk_d       = atk_q;
        mid_d       = mid_q;
        base_d      = base_q;
        dmg_d       = dmg_q;
        roll_crit_d = roll_crit_q;
        user_hp_d   = user_hp_q;
        boss_hp_d   = boss_hp_q;
        damage_d    = damage_q;
        crit_d      = crit_q;
        scaled      = roll_hit ? {base_q, 1'b0} : {1'b0, base_q};

        if (init) begin
            state_d   = ST_IDLE;
            user_hp_d = USER_HP_INIT;
            boss_hp_d = BOSS_HP_INIT;
            damage_d  = '0;
            crit_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        atk_d   = attacker_t'(attacker);
                        mid_d   = move_id;
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    base_d  = base_power(atk_q, mid_q);
                    state_d = ST_ROLL;
                end
                ST_ROLL: begin
                    roll_crit_d = roll_hit;
                    dmg_d       = (scaled > 10'd255) ? 8'd255 : scaled[7:0];
                    state_d     = ST_APPLY;
                end
                ST_APPLY: begin
                    // The HP write and the reported result land on the same edge.
                    if (atk_q == ATK_USER) begin
                        boss_hp_d = (boss_hp_q > dmg_q) ? boss_hp_q - dmg_q : '0;
                    end else begin
                        user_hp_d = (user_hp_q > dmg_q) ? user_hp_q - dmg_q : '0;
                    end
                    damage_d = dmg_q;
                    crit_d   = roll_crit_q;
                    state_d  = ST_RESP;
                end
                ST_RESP: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            atk_q       <= ATK_USER;
            mid_q       <= '0;
            base_q      <= '0;
            dmg_q       <= '0;
            roll_crit_q <= 1'b0;
            user_hp_q   <= USER_HP_INIT;
            boss_hp_q   <= BOSS_HP_INIT;
            damage_q    <= '0;
            crit_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            atk_q       <= atk_d;
            mid_q       <= mid_d;
            base_q      <= base_d;
            dmg_q       <= dmg_d;
            roll_crit_q <= roll_crit_d;
            user_hp_q   <= user_hp_d;
            boss_hp_q   <= boss_hp_d;
            damage_q    <= damage_d;
            crit_q      <= crit_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = (state_q == ST_RESP);
    assign damage       = damage_q;
    assign crit         = crit_q;
    assign user_hp      = user_hp_q;
    assign boss_hp      = boss_hp_q;
    assign user_fainted = (user_hp_q == '0);
    assign boss_fainted = (boss_hp_q == '0);

endmodule
